// File: rtl/sb_pattern_detector_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sb_pattern_detector_if : SBINIT pattern-detector control/data bundle     |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
interface sb_pattern_detector_if #(
  parameter int PATTERN_WIDTH = 64,
  parameter int MATCH_COUNT   = 2
);
  localparam int CNT_W = $clog2(MATCH_COUNT + 1);

  logic                     i_en;
  logic [PATTERN_WIDTH-1:0] i_deser_data;
  logic                     i_deser_valid;
  logic                     o_rx_sb_pattern_samp_done;
  logic                     o_pattern_locked;
  logic                     o_timeout;
  logic [CNT_W-1:0]         o_match_cnt;

  modport master (
    output i_en, i_deser_data, i_deser_valid,
    input  o_rx_sb_pattern_samp_done, o_pattern_locked, o_timeout, o_match_cnt
  );

  modport slave (
    input  i_en, i_deser_data, i_deser_valid,
    output o_rx_sb_pattern_samp_done, o_pattern_locked, o_timeout, o_match_cnt
  );
endinterface
`default_nettype wire

// File: rtl/sb_pattern_detector.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sb_pattern_detector : locks on consecutive alternating-clock sideband    |
// | words during SBINIT, strobes samp_done on lock, flags search timeout.    |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module sb_pattern_detector #(
  parameter int PATTERN_WIDTH  = 64,
  parameter int MATCH_COUNT    = 2,
  parameter int TIMEOUT_CYCLES = 800000
) (
  input  wire                  i_clk,
  input  wire                  i_rst,
  sb_pattern_detector_if.slave sb
);
  localparam int CNT_W = $clog2(MATCH_COUNT + 1);
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PATTERN_WIDTH-1:0] C_PAT_A    = {(PATTERN_WIDTH/2){2'b10}};
  localparam logic [PATTERN_WIDTH-1:0] C_PAT_B    = {(PATTERN_WIDTH/2){2'b01}};
  localparam logic [CNT_W-1:0]         C_CNT_LOCK = CNT_W'(MATCH_COUNT);
  localparam logic [TO_W-1:0]          C_TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_phase, w_phase_nxt;
  logic [TO_W-1:0]  r_tcnt, w_tcnt_nxt;
  logic             r_strobe, w_strobe_nxt;
  logic             r_locked, r_timeout;

  logic w_is_a, w_is_b, w_word_phase;

  assign w_is_a       = (sb.i_deser_data == C_PAT_A);
  assign w_is_b       = (sb.i_deser_data == C_PAT_B);
  assign w_word_phase = w_is_b;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_phase_nxt  = r_phase;
    w_tcnt_nxt   = r_tcnt;
    w_strobe_nxt = 1'b0;
    if (!sb.i_en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
      w_tcnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_SEARCH;
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_tcnt_nxt  = '0;
        end
        S_SEARCH: begin
          if (sb.i_deser_valid) begin
            if (w_is_a || w_is_b) begin
              // A phase flip means the previous run was not the same clock alignment
              if ((r_cnt == '0) || (w_word_phase == r_phase)) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
              end else begin
                w_cnt_nxt = CNT_W'(1);
              end
              w_phase_nxt = w_word_phase;
            end else begin
              w_cnt_nxt = '0;
            end
          end
          // Lock takes precedence over an expiry on the same edge
          if (w_cnt_nxt == C_CNT_LOCK) begin
            w_state_nxt  = S_DONE;
            w_strobe_nxt = 1'b1;
          end else if (r_tcnt == C_TO_LAST) begin
            w_state_nxt = S_TIMEOUT;
          end else begin
            w_tcnt_nxt = r_tcnt + TO_W'(1);
          end
        end
        S_DONE, S_TIMEOUT: ;
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_tcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_phase   <= 1'b0;
      r_tcnt    <= '0;
      r_strobe  <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_strobe  <= w_strobe_nxt;
      r_locked  <= (w_state_nxt == S_DONE);
      r_timeout <= (w_state_nxt == S_TIMEOUT);
    end
  end

  assign sb.o_rx_sb_pattern_samp_done = r_strobe;
  assign sb.o_pattern_locked          = r_locked;
  assign sb.o_timeout                 = r_timeout;
  assign sb.o_match_cnt               = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sb_pattern_detector.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_sb_pattern_detector : vector table, corner sequences, random vs model |
// | Rev 1.0                                                                  |
// +-------------------------------------------------------------------------+
module tb_sb_pattern_detector;
  localparam int PW = 64;
  localparam int MC = 2;
  localparam int TO = 100;
  localparam logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] PB = 64'h5555_5555_5555_5555;
  localparam logic [63:0] PX = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sb_pattern_detector_if #(.PATTERN_WIDTH(PW), .MATCH_COUNT(MC)) bus ();

  sb_pattern_detector #(
    .PATTERN_WIDTH (PW),
    .MATCH_COUNT   (MC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .sb   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: match count is the length of the trailing run of
  // identical pattern words among the valid words seen since search began.
  int          m_mode = 0;  // 0 idle, 1 search, 2 done, 3 timeout
  logic [63:0] m_words[$];
  int          m_cyc = 0;
  int          m_cnt = 0;
  bit          m_strobe = 0;

  function automatic int trailing_run();
    logic [63:0] last;
    int n = 0;
    if (m_words.size() == 0) return 0;
    last = m_words[m_words.size()-1];
    if (last != PA && last != PB) return 0;
    for (int i = m_words.size() - 1; i >= 0; i--) begin
      if (m_words[i] == last) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_step(input bit r, input bit e, input bit v, input logic [63:0] d);
    m_strobe = 0;
    if (r || !e) begin
      m_mode = 0; m_words.delete(); m_cyc = 0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_words.delete(); m_cyc = 0; m_cnt = 0;
    end else if (m_mode == 1) begin
      if (v) m_words.push_back(d);
      m_cnt = trailing_run();
      if (m_cnt >= MC) begin
        m_mode = 2; m_strobe = 1;
      end else if (m_cyc >= TO - 1) begin
        m_mode = 3;
      end else begin
        m_cyc++;
      end
    end
  endtask

  task automatic apply(input bit r, input bit e, input bit v, input logic [63:0] d);
    rst               = r;
    bus.i_en          = e;
    bus.i_deser_valid = v;
    bus.i_deser_data  = d;
    @(posedge clk);
    #1;
    model_step(r, e, v, d);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".strobe"},  bus.o_rx_sb_pattern_samp_done, 64'(m_strobe));
    chk({tag, ".locked"},  bus.o_pattern_locked,          64'(m_mode == 2));
    chk({tag, ".timeout"}, bus.o_timeout,                 64'(m_mode == 3));
    chk({tag, ".cnt"},     64'(bus.o_match_cnt),          64'(m_cnt));
  endtask

  task automatic expect4(input string tag, input bit s, input bit l, input bit t, input int c);
    chk({tag, ".strobe"},  bus.o_rx_sb_pattern_samp_done, 64'(s));
    chk({tag, ".locked"},  bus.o_pattern_locked,          64'(l));
    chk({tag, ".timeout"}, bus.o_timeout,                 64'(t));
    chk({tag, ".cnt"},     64'(bus.o_match_cnt),          64'(c));
  endtask

  typedef struct {
    bit          rst, en, valid;
    logic [63:0] data;
    bit          strobe, locked, timeout;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit v, logic [63:0] d, bit s, bit l, bit t, int c);
    vec_t x;
    x.rst = r; x.en = e; x.valid = v; x.data = d;
    x.strobe = s; x.locked = l; x.timeout = t; x.cnt = c;
    return x;
  endfunction

  initial begin
    bus.i_en = 1'b0; bus.i_deser_valid = 1'b0; bus.i_deser_data = '0;

    // rst en v data            strobe lock to cnt
    tbl.push_back(mk(1, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, PA, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, PA, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 2));
    tbl.push_back(mk(0, 1, 1, PB, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, PA, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, PB, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, PB, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, PA, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, PX, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, PA, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, PA, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].en, tbl[i].valid, tbl[i].data);
      expect4($sformatf("tbl%0d", i), tbl[i].strobe, tbl[i].locked, tbl[i].timeout, tbl[i].cnt);
    end

    // Timeout with no valid words, then matching words must be ignored
    begin
      int k = 0;
      bit seen = 0;
      apply(0, 0, 0, 0);
      apply(0, 1, 0, 0);
      for (int j = 1; j <= 200; j++) begin
        apply(0, 1, 0, 0);
        check_model($sformatf("to%0d", j));
        if (bus.o_rx_sb_pattern_samp_done) seen = 1;
        if (bus.o_timeout) begin
          k = j;
          break;
        end
      end
      chk("to_latency", 64'(k), 64'd100);
      chk("to_nostrobe", 64'(seen), 64'd0);
      apply(0, 1, 1, PA);
      apply(0, 1, 1, PA);
      expect4("to_sticky", 0, 0, 1, 0);
    end

    // Lock-completing word on the expiry edge
    apply(0, 0, 0, 0);
    apply(0, 1, 0, 0);
    for (int j = 1; j <= 98; j++) apply(0, 1, 0, 0);
    apply(0, 1, 1, PA);
    expect4("exp_first", 0, 0, 0, 1);
    apply(0, 1, 1, PA);
    expect4("exp_lock", 1, 1, 0, 2);
    apply(0, 1, 0, 0);
    expect4("exp_after", 0, 1, 0, 2);

    // Enable drop (with a matching word on the same edge) discards progress
    apply(0, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 1, 1, PA);
    expect4("en_first", 0, 0, 0, 1);
    apply(0, 0, 1, PA);
    expect4("en_low", 0, 0, 0, 0);
    apply(0, 1, 0, 0);
    expect4("en_entry", 0, 0, 0, 0);
    apply(0, 1, 1, PA);
    expect4("en_restart", 0, 0, 0, 1);
    apply(0, 1, 1, PA);
    expect4("en_lock", 1, 1, 0, 2);

    // Same sequence with reset pulsed while enable stays high
    apply(0, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 1, 1, PA);
    expect4("rst_first", 0, 0, 0, 1);
    apply(1, 1, 1, PA);
    expect4("rst_during", 0, 0, 0, 0);
    apply(0, 1, 0, 0);
    expect4("rst_entry", 0, 0, 0, 0);
    apply(0, 1, 1, PA);
    expect4("rst_restart", 0, 0, 0, 1);
    apply(0, 1, 1, PA);
    expect4("rst_lock", 1, 1, 0, 2);

    // Random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      bit          r, e, v;
      logic [63:0] d;
      int          sel;
      r   = ($urandom_range(0, 99) == 0);
      e   = ($urandom_range(0, 29) != 0);
      v   = $urandom_range(0, 1) != 0;
      sel = $urandom_range(0, 9);
      if (sel < 4)       d = PA;
      else if (sel < 8)  d = PB;
      else if (sel == 8) d = PX;
      else               d = {$urandom, $urandom};
      apply(r, e, v, d);
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
